// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg : opcode and sequencer state types shared by the ALU front end. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_LSH = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SUB = 3'b100,
    OP_RSH = 3'b101,
    OP_CMP = 3'b110,
    OP_RSV = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } alu_seq_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_LSH) || (op == OP_RSH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : valid/ready front end driving an external ALU, with repeated shift
//           passes. Optional macro ALU_SEQ_PARITY_EN enables rsp_par. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [OP_W-1:0]  req_op,
  input  logic [CNT_W-1:0] req_cnt,
  output logic [W-1:0]     DatA,
  output logic [W-1:0]     DatB,
  output logic [OP_W-1:0]  ALUop,
  input  logic [W-1:0]     Rslt,
  input  logic             Zero,
  input  logic             Par,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_rslt,
  output logic             rsp_zero,
  output logic             rsp_par
);

  alu_seq_state_t   state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [W-1:0]     dat_a_q,    dat_a_d;
  logic [W-1:0]     dat_b_q,    dat_b_d;
  alu_op_t          alu_op_q,   alu_op_d;
  logic [W-1:0]     rsp_rslt_q, rsp_rslt_d;
  logic             rsp_zero_q, rsp_zero_d;
`ifdef ALU_SEQ_PARITY_EN
  logic             rsp_par_q,  rsp_par_d;
`endif

  logic [CNT_W-1:0] cnt_load;
  alu_op_t          req_op_e;

  assign req_op_e = alu_op_t'(req_op);

  // Reset gates ready so no request is taken while the block is held in reset.
  assign req_ready = (state_q == ST_IDLE) && !Reset;
  assign rsp_valid = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dat_a_d    = dat_a_q;
    dat_b_d    = dat_b_q;
    alu_op_d   = alu_op_q;
    rsp_rslt_d = rsp_rslt_q;
    rsp_zero_d = rsp_zero_q;
`ifdef ALU_SEQ_PARITY_EN
    rsp_par_d  = rsp_par_q;
`endif
    cnt_load   = is_shift(req_op_e) ? req_cnt : CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (cnt_load != '0) begin
            state_d  = ST_ISSUE;
            cnt_d    = cnt_load;
            dat_a_d  = req_a;
            dat_b_d  = req_b;
            alu_op_d = req_op_e;
          end else begin
            // Zero-pass shift: answer straight from operand A, ALU untouched.
            state_d    = ST_DONE;
            rsp_rslt_d = req_a;
            rsp_zero_d = (req_a == '0);
`ifdef ALU_SEQ_PARITY_EN
            rsp_par_d  = ^req_a;
`endif
          end
        end
      end

      ST_ISSUE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_DONE;
          rsp_rslt_d = Rslt;
          rsp_zero_d = Zero;
`ifdef ALU_SEQ_PARITY_EN
          rsp_par_d  = Par;
`endif
        end else begin
          dat_a_d = Rslt;
        end
      end

      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dat_a_q    <= '0;
      dat_b_q    <= '0;
      alu_op_q   <= OP_ADD;
      rsp_rslt_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dat_a_q    <= dat_a_d;
      dat_b_q    <= dat_b_d;
      alu_op_q   <= alu_op_d;
      rsp_rslt_q <= rsp_rslt_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

`ifdef ALU_SEQ_PARITY_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_par_q <= 1'b0;
    end else begin
      rsp_par_q <= rsp_par_d;
    end
  end

  assign rsp_par = rsp_par_q;
`else
  logic par_unused;
  assign par_unused = Par;
  assign rsp_par    = 1'b0;
`endif

  assign DatA     = dat_a_q;
  assign DatB     = dat_b_q;
  assign ALUop    = alu_op_q;
  assign rsp_rslt = rsp_rslt_q;
  assign rsp_zero = rsp_zero_q;

endmodule

`default_nettype wire
